// File: rtl/arith_unit_pipe.sv
// Signed add/sub/mul/div/rem unit with valid/ready handshakes, one operation in flight.
// Define ARITH_DIV_EN to build the iterative restoring divider; otherwise div/rem flag err.
module arith_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  localparam logic [2:0]       OP_ADD = 3'd0;
  localparam logic [2:0]       OP_SUB = 3'd1;
  localparam logic [2:0]       OP_MUL = 3'd2;
  localparam logic [2:0]       OP_DIV = 3'd3;
  localparam logic [2:0]       OP_REM = 3'd4;
  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef ARITH_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] exec_r_s;
  logic             exec_err_s;
  logic             accept_s;

  assign accept_s = in_valid && in_ready;

`ifdef ARITH_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_r, dvs_r, rem_r;
  logic [WIDTH:0]   trial_s, diff_s;
  logic             is_div_s;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) abs_f = -v;
    else            abs_f = v;
  endfunction

  // q_r starts as |a| and is shifted out into the partial remainder MSB first.
  assign trial_s  = {rem_r, q_r[WIDTH-1]};
  assign diff_s   = trial_s - {1'b0, dvs_r};
  assign is_div_s = ((op == OP_DIV) || (op == OP_REM)) && (b != ZERO);
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef ARITH_DIV_EN
          if (is_div_s) state_s = DIV;
          else          state_s = EXEC;
`else
          state_s = EXEC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = DONE;
`ifdef ARITH_DIV_EN
      DIV: begin
        if (cnt_r == CW'(WIDTH)) state_s = DONE;
        else                     state_s = DIV;
      end
`endif
      DONE: begin
        if (out_valid && out_ready) state_s = IDLE;
        else                        state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Single-cycle result for everything except a real division.
  always_comb begin
    exec_r_s   = ZERO;
    exec_err_s = 1'b0;
    case (op_r)
      OP_ADD: exec_r_s = a_r + b_r;
      OP_SUB: exec_r_s = a_r - b_r;
      OP_MUL: exec_r_s = a_r * b_r;
`ifdef ARITH_DIV_EN
      OP_DIV: begin
        exec_r_s   = ONES;
        exec_err_s = 1'b1;
      end
      OP_REM: begin
        exec_r_s   = a_r;
        exec_err_s = 1'b1;
      end
`endif
      default: begin
        exec_r_s   = ZERO;
        exec_err_s = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Handshake outputs; out_valid rises one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_r == DONE) && !(out_valid && out_ready);
    end
  end

  // Operand capture, result register and divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= ZERO;
      b_r   <= ZERO;
      op_r  <= OP_ADD;
      r     <= ZERO;
      err   <= 1'b0;
`ifdef ARITH_DIV_EN
      cnt_r <= {CW{1'b0}};
      q_r   <= ZERO;
      dvs_r <= ZERO;
      rem_r <= ZERO;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
`ifdef ARITH_DIV_EN
            q_r   <= abs_f(a);
            dvs_r <= abs_f(b);
            rem_r <= ZERO;
            cnt_r <= {CW{1'b0}};
`endif
          end
        end
        EXEC: begin
          r   <= exec_r_s;
          err <= exec_err_s;
        end
`ifdef ARITH_DIV_EN
        DIV: begin
          if (cnt_r != CW'(WIDTH)) begin
            cnt_r <= cnt_r + CW'(1'b1);
            if (!diff_s[WIDTH]) begin
              rem_r <= diff_s[WIDTH-1:0];
              q_r   <= {q_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r <= trial_s[WIDTH-1:0];
              q_r   <= {q_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            // Truncating quotient; remainder follows the sign of a.
            err <= 1'b0;
            if (op_r == OP_DIV) r <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -q_r : q_r;
            else                r <= a_r[WIDTH-1] ? -rem_r : rem_r;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
